// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU: opcodes, FSM states, ALU selects
// and instruction field positions.
package cpu_pkg;

  localparam logic [7:0] OP_LOADI = 8'd0;
  localparam logic [7:0] OP_MOV   = 8'd1;
  localparam logic [7:0] OP_ADD   = 8'd2;
  localparam logic [7:0] OP_SUB   = 8'd3;
  localparam logic [7:0] OP_AND   = 8'd4;
  localparam logic [7:0] OP_OR    = 8'd5;
  localparam logic [7:0] OP_J     = 8'd6;
  localparam logic [7:0] OP_BEQ   = 8'd7;
  localparam logic [7:0] OP_BNE   = 8'd8;
  localparam logic [7:0] OP_LWD   = 8'd9;
  localparam logic [7:0] OP_LWI   = 8'd10;
  localparam logic [7:0] OP_SWD   = 8'd11;
  localparam logic [7:0] OP_SWI   = 8'd12;
  localparam logic [7:0] OP_SLL   = 8'd13;
  localparam logic [7:0] OP_SRL   = 8'd14;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_WB} state_t;

  typedef enum logic [2:0] {
    ALU_FWD, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLL, ALU_SRL
  } alu_sel_t;

  localparam int OPC_LSB  = 24;
  localparam int DST_LSB  = 16;
  localparam int SRC1_LSB = 8;
  localparam int SRC2_LSB = 0;

endpackage

// File: rtl/cpu_multicycle_alu.sv
// Parametrised ALU: forward, add, sub, and, or, logical shifts; ZERO flags a
// zero result for branch compares.
module alu_param
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_sel_t          sel,
  input  logic [7:0]        shamt,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  logic shift_oor;
  assign shift_oor = int'(shamt) >= DATA_W;

  always_comb begin
    result = b;
    case (sel)
      ALU_FWD: result = b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a + ~b + DATA_W'(1);
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLL: result = shift_oor ? '0 : a << shamt;
      ALU_SRL: result = shift_oor ? '0 : a >> shamt;
      default: result = b;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/cpu_multicycle.sv
// Multi-cycle CPU core: FETCH/EXEC/MEM/WB sequencing with busywait stalls on
// both instruction and data memory.
module cpu_multicycle
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8,
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  output logic [31:0]       PC,
  input  logic [31:0]       INSTRUCTION,
  input  logic              INSTR_BUSYWAIT,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WRITEDATA,
  input  logic [DATA_W-1:0] MEM_READDATA,
  input  logic              MEM_BUSYWAIT
);

  localparam int IDX_W = $clog2(NREGS);

  state_t            state, state_n;
  logic [31:0]       ir, pc_n, pc4, br_target;
  logic [DATA_W-1:0] regs [NREGS];
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] wdata_q, rdata_q;

  logic [7:0]        opc, imm, offset;
  logic [IDX_W-1:0]  dst, src1, src2;
  logic [DATA_W-1:0] rs1, rs2, simm, op_b, alu_res, wr_data;
  alu_sel_t          alu_sel;
  logic              alu_zero, wr_en, is_load, is_store;
  logic              unused_src1_hi;

  assign opc            = ir[OPC_LSB +: 8];
  assign offset         = ir[DST_LSB +: 8];
  assign imm            = ir[SRC2_LSB +: 8];
  assign dst            = ir[DST_LSB +: IDX_W];
  assign src1           = ir[SRC1_LSB +: IDX_W];
  assign src2           = ir[SRC2_LSB +: IDX_W];
  assign unused_src1_hi = ^ir[SRC1_LSB +: 8];

  assign rs1       = regs[src1];
  assign rs2       = regs[src2];
  assign simm      = DATA_W'($signed(imm));
  assign pc4       = PC + 32'd4;
  assign br_target = pc4 + (32'($signed(offset)) << 2);
  assign is_load   = (opc == OP_LWD) || (opc == OP_LWI);
  assign is_store  = (opc == OP_SWD) || (opc == OP_SWI);
  assign addr_n    = ((opc == OP_LWD) || (opc == OP_SWD)) ? ADDR_W'(rs2) : ADDR_W'(imm);

  // Operand selection depends only on IR, so it stays apart from the control
  // block that consumes the ALU ZERO flag.
  always_comb begin
    alu_sel = ALU_FWD;
    op_b    = rs2;
    case (opc)
      OP_LOADI:                op_b    = simm;
      OP_ADD:                  alu_sel = ALU_ADD;
      OP_SUB, OP_BEQ, OP_BNE:  alu_sel = ALU_SUB;
      OP_AND:                  alu_sel = ALU_AND;
      OP_OR:                   alu_sel = ALU_OR;
      OP_SLL:                  alu_sel = ALU_SLL;
      OP_SRL:                  alu_sel = ALU_SRL;
      default:                 alu_sel = ALU_FWD;
    endcase
  end

  alu_param #(.DATA_W(DATA_W)) u_alu (
    .a      (rs1),
    .b      (op_b),
    .sel    (alu_sel),
    .shamt  (imm),
    .result (alu_res),
    .zero   (alu_zero)
  );

  always_comb begin
    state_n = state;
    pc_n    = PC;
    wr_en   = 1'b0;
    wr_data = alu_res;
    case (state)
      S_FETCH: if (!INSTR_BUSYWAIT) state_n = S_EXEC;
      S_EXEC: begin
        state_n = S_FETCH;
        pc_n    = pc4;
        case (opc)
          OP_LOADI, OP_MOV, OP_ADD, OP_SUB,
          OP_AND, OP_OR, OP_SLL, OP_SRL:    wr_en = 1'b1;
          OP_J:                             pc_n  = br_target;
          OP_BEQ: if (alu_zero)             pc_n  = br_target;
          OP_BNE: if (!alu_zero)            pc_n  = br_target;
          OP_LWD, OP_LWI, OP_SWD, OP_SWI: begin
            state_n = S_MEM;
            pc_n    = PC;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        if (!MEM_BUSYWAIT) begin
          if (is_load) begin
            state_n = S_WB;
          end else begin
            state_n = S_FETCH;
            pc_n    = pc4;
          end
        end
      end
      S_WB: begin
        state_n = S_FETCH;
        pc_n    = pc4;
        wr_en   = 1'b1;
        wr_data = rdata_q;
      end
      default: state_n = S_FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= S_FETCH;
    else       state <= state_n;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      PC      <= '0;
      ir      <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      PC <= pc_n;
      if (state == S_FETCH && !INSTR_BUSYWAIT) ir <= INSTRUCTION;
      if (state == S_EXEC) begin
        addr_q  <= addr_n;
        wdata_q <= rs1;
      end
      if (state == S_MEM && !MEM_BUSYWAIT) rdata_q <= MEM_READDATA;
      if (wr_en) regs[dst] <= wr_data;
    end
  end

  assign MEM_READ      = (state == S_MEM) && is_load;
  assign MEM_WRITE     = (state == S_MEM) && is_store;
  assign MEM_ADDR      = (state == S_MEM) ? addr_q : '0;
  assign MEM_WRITEDATA = MEM_WRITE ? wdata_q : '0;

endmodule

// File: tb/tb_cpu_multicycle.sv
// Bench for cpu_multicycle: an 8-bit/8-reg and a 16-bit/16-reg core run the
// same programs; register contents are observed through stores.
module tb_cpu_multicycle;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, ibusy;
  logic [31:0] pc0, pc1, ins0, ins1;
  logic        r0, w0, r1, w1, mbusy;
  logic [7:0]  a0, a1, wd0, rd0;
  logic [15:0] wd1, rd1;

  logic [31:0] imem  [64];
  logic [15:0] dmem0 [256];
  logic [15:0] dmem1 [256];
  int          mem_wait, mcnt;

  typedef struct packed { logic [7:0] addr; logic [15:0] data; } st_t;
  st_t q0[$], q1[$];
  int checks = 0, errors = 0;
  int wcyc = 0, scyc = 0;

  always #5 clk = ~clk;

  cpu_multicycle #(.DATA_W(8), .NREGS(8), .ADDR_W(8)) dut0 (
    .CLK(clk), .RESET(rst), .PC(pc0), .INSTRUCTION(ins0), .INSTR_BUSYWAIT(ibusy),
    .MEM_READ(r0), .MEM_WRITE(w0), .MEM_ADDR(a0), .MEM_WRITEDATA(wd0),
    .MEM_READDATA(rd0), .MEM_BUSYWAIT(mbusy)
  );

  cpu_multicycle #(.DATA_W(16), .NREGS(16), .ADDR_W(8)) dut1 (
    .CLK(clk), .RESET(rst), .PC(pc1), .INSTRUCTION(ins1), .INSTR_BUSYWAIT(ibusy),
    .MEM_READ(r1), .MEM_WRITE(w1), .MEM_ADDR(a1), .MEM_WRITEDATA(wd1),
    .MEM_READDATA(rd1), .MEM_BUSYWAIT(mbusy)
  );

  assign ins0  = imem[pc0[7:2]];
  assign ins1  = imem[pc1[7:2]];
  assign rd0   = dmem0[a0][7:0];
  assign rd1   = dmem1[a1];
  assign mbusy = (r0 | w0) && (mcnt < mem_wait);

  // Data memory: busy for mem_wait cycles after a strobe rises.
  always @(posedge clk) begin
    if ((r0 | w0) && mbusy) mcnt <= mcnt + 1;
    else                    mcnt <= 0;
    if (w0 && !mbusy) dmem0[a0] <= {8'h00, wd0};
    if (w1 && !mbusy) dmem1[a1] <= wd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  logic       pw [2] = '{1'b0, 1'b0};
  logic       pr [2] = '{1'b0, 1'b0};
  logic [7:0] la [2];
  logic [15:0] ld [2];

  task automatic mon(input int id, input logic r, input logic w,
                     input logic [7:0] a, input logic [15:0] d);
    st_t e;
    check($sformatf("strobe_excl%0d", id), {31'b0, r & w}, 32'd0);
    if (id == 0 && (r | w)) scyc++;
    if (id == 0 && w) wcyc++;
    if (w && !pw[id]) begin
      if ((id == 0 ? q0.size() : q1.size()) == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_store%0d: addr 0x%0h data 0x%0h, none expected", id, a, d);
      end else begin
        e = (id == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("store_addr%0d", id), {24'b0, a}, {24'b0, e.addr});
        check($sformatf("store_data%0d", id), {16'b0, d}, {16'b0, e.data});
      end
      la[id] = a;
      ld[id] = d;
    end else if ((w && pw[id]) || (r && pr[id])) begin
      check($sformatf("addr_stable%0d", id), {24'b0, a}, {24'b0, la[id]});
      if (w) check($sformatf("data_stable%0d", id), {16'b0, d}, {16'b0, ld[id]});
    end
    if (r && !pr[id]) la[id] = a;
    pw[id] = w;
    pr[id] = r;
  endtask

  always @(negedge clk) begin
    mon(0, r0, w0, a0, {8'h00, wd0});
    mon(1, r1, w1, a1, wd1);
  end

  function automatic logic [31:0] ins(input logic [7:0] op, input logic [7:0] d,
                                      input logic [7:0] s1, input logic [7:0] s2);
    return {op, d, s1, s2};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) imem[i] = 32'hFF00_0000;
  endtask

  task automatic expect_store(input logic [7:0] addr, input logic [7:0] d8, input logic [15:0] d16);
    q0.push_back('{addr, {8'h00, d8}});
    q1.push_back('{addr, d16});
  endtask

  task automatic check_pc(input string name, input logic [31:0] exp);
    check({name, "_pc8"}, pc0, exp);
    check({name, "_pc16"}, pc1, exp);
  endtask

  task automatic check_drained(input string name);
    check({name, "_q8"}, q0.size(), 32'd0);
    check({name, "_q16"}, q1.size(), 32'd0);
  endtask

  task automatic br_test(input string name, input logic [7:0] op,
                         input logic [7:0] b, input logic [31:0] exp_pc);
    clear_prog();
    imem[0] = ins(OP_LOADI, 8'd1, 8'd0, 8'd7);
    imem[1] = ins(OP_LOADI, 8'd2, 8'd0, b);
    imem[2] = ins(op, 8'hFE, 8'd1, 8'd2);
    do_reset();
    step(6);
    check_pc(name, exp_pc);
  endtask

  typedef struct packed {
    logic [7:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  e8;
    logic [15:0] e16;
  } vec_t;

  vec_t tv [13];
  int   s0;
  logic [7:0] addr;

  initial begin
    rst = 1'b1; ibusy = 1'b0; mem_wait = 0; mcnt = 0;
    for (int i = 0; i < 256; i++) begin dmem0[i] = '0; dmem1[i] = '0; end
    clear_prog();

    // Reset state
    do_reset();
    check_pc("reset", 32'd0);
    check("reset_strobes8", {30'b0, r0, w0}, 32'd0);
    check("reset_strobes16", {30'b0, r1, w1}, 32'd0);
    check("reset_addr", {a0, wd0, a1}, 32'd0);
    check("reset_wdata16", {16'b0, wd1}, 32'd0);

    // ALU vectors: loadi r1,a; loadi r2,b; op r3; swi r3
    tv[0]  = '{OP_ADD,   8'h7F, 8'h01, 8'h80, 16'h0080};
    tv[1]  = '{OP_SUB,   8'h05, 8'h03, 8'h02, 16'h0002};
    tv[2]  = '{OP_SUB,   8'h03, 8'h05, 8'hFE, 16'hFFFE};
    tv[3]  = '{OP_AND,   8'hF0, 8'h3C, 8'h30, 16'h0030};
    tv[4]  = '{OP_OR,    8'h81, 8'h02, 8'h83, 16'hFF83};
    tv[5]  = '{OP_SLL,   8'h03, 8'h09, 8'h00, 16'h0600};
    tv[6]  = '{OP_SLL,   8'h03, 8'h07, 8'h80, 16'h0180};
    tv[7]  = '{OP_SRL,   8'h80, 8'h04, 8'h08, 16'h0FF8};
    tv[8]  = '{OP_SRL,   8'h80, 8'h10, 8'h00, 16'h0000};
    tv[9]  = '{OP_LOADI, 8'h00, 8'h80, 8'h80, 16'hFF80};
    tv[10] = '{OP_ADD,   8'hFF, 8'hFF, 8'hFE, 16'hFFFE};
    tv[11] = '{OP_SRL,   8'h80, 8'h0F, 8'h00, 16'h0001};
    tv[12] = '{OP_SLL,   8'h03, 8'h08, 8'h00, 16'h0300};
    for (int i = 0; i < 13; i++) begin
      clear_prog();
      addr = 8'h20 + 8'(i);
      imem[0] = ins(OP_LOADI, 8'd1, 8'd0, tv[i].a);
      imem[1] = ins(OP_LOADI, 8'd2, 8'd0, tv[i].b);
      if (tv[i].op == OP_LOADI)
        imem[2] = ins(OP_LOADI, 8'd3, 8'd0, tv[i].b);
      else if (tv[i].op == OP_SLL || tv[i].op == OP_SRL)
        imem[2] = ins(tv[i].op, 8'd3, 8'd1, tv[i].b);
      else
        imem[2] = ins(tv[i].op, 8'd3, 8'd1, 8'd2);
      imem[3] = ins(OP_SWI, 8'd0, 8'd3, addr);
      expect_store(addr, tv[i].e8, tv[i].e16);
      do_reset();
      step(9);
      check_pc($sformatf("alu%0d", i), 32'd16);
      check_drained($sformatf("alu%0d", i));
    end

    // Zero-wait timing: three ALU ops in 6 cycles, no strobes
    clear_prog();
    imem[0] = ins(OP_LOADI, 8'd1, 8'd0, 8'd5);
    imem[1] = ins(OP_LOADI, 8'd2, 8'd0, 8'd3);
    imem[2] = ins(OP_SUB,   8'd3, 8'd1, 8'd2);
    imem[3] = ins(OP_SWI,   8'd0, 8'd3, 8'h01);
    expect_store(8'h01, 8'h02, 16'h0002);
    do_reset();
    s0 = scyc;
    step(6);
    check_pc("seq6", 32'd12);
    check("seq6_no_strobe", scyc - s0, 32'd0);
    step(3);
    check_pc("seq9", 32'd16);
    check_drained("seq");

    // Register index truncation: r9 aliases r1 with 8 registers
    clear_prog();
    imem[0] = ins(OP_LOADI, 8'd9, 8'd0, 8'd7);
    imem[1] = ins(OP_SWI,   8'd0, 8'd1, 8'h50);
    imem[2] = ins(OP_SWI,   8'd0, 8'd9, 8'h51);
    expect_store(8'h50, 8'h07, 16'h0000);
    expect_store(8'h51, 8'h07, 16'h0007);
    do_reset();
    step(8);
    check_pc("alias", 32'd12);
    check_drained("alias");

    // Branches
    br_test("beq_taken",    OP_BEQ, 8'd7, 32'd4);
    br_test("beq_nottaken", OP_BEQ, 8'd6, 32'd12);
    br_test("bne_nottaken", OP_BNE, 8'd7, 32'd12);
    br_test("bne_taken",    OP_BNE, 8'd6, 32'd4);
    clear_prog();
    imem[0] = ins(OP_J, 8'h03, 8'd0, 8'd0);
    do_reset();
    step(2);
    check_pc("j_fwd", 32'd16);
    imem[0] = ins(OP_J, 8'hFF, 8'd0, 8'd0);
    do_reset();
    step(2);
    check_pc("j_back", 32'd0);

    // Store with 3 busywait cycles, then load back with 2
    clear_prog();
    imem[0] = ins(OP_LOADI, 8'd1, 8'd0, 8'h2A);
    imem[1] = ins(OP_SWI,   8'd0, 8'd1, 8'h10);
    imem[2] = ins(OP_LWI,   8'd5, 8'd0, 8'h10);
    imem[3] = ins(OP_SWI,   8'd0, 8'd5, 8'h11);
    expect_store(8'h10, 8'h2A, 16'h002A);
    expect_store(8'h11, 8'h2A, 16'h002A);
    mem_wait = 3;
    do_reset();
    s0 = wcyc;
    step(8);
    check_pc("sw_wait", 32'd8);
    check("sw_wait_cycles", wcyc - s0, 32'd4);
    mem_wait = 2;
    step(5);
    check_pc("lw_wb", 32'd8);
    check("lw_wb_read_low", {31'b0, r0}, 32'd0);
    step(1);
    check_pc("lw_done", 32'd12);
    step(5);
    check_pc("sw2_done", 32'd16);
    check_drained("memwait");

    // Instruction busywait for 5 cycles
    clear_prog();
    imem[0] = ins(OP_LOADI, 8'd1, 8'd0, 8'd9);
    imem[1] = ins(OP_SWI,   8'd0, 8'd1, 8'h30);
    expect_store(8'h30, 8'h09, 16'h0009);
    mem_wait = 0;
    ibusy = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1);
      check_pc($sformatf("ibusy%0d", i), 32'd0);
    end
    ibusy = 1'b0;
    step(1);
    check_pc("ibusy_exec", 32'd0);
    step(1);
    check_pc("ibusy_done", 32'd4);
    step(3);
    check_pc("ibusy_store", 32'd8);
    check_drained("ibusy");

    // Reset during the 2nd busywait cycle of lwd
    clear_prog();
    imem[0] = ins(OP_LOADI, 8'd2, 8'd0, 8'h40);
    imem[1] = ins(OP_LWD,   8'd6, 8'd0, 8'd2);
    dmem0[8'h40] = 16'h0055;
    dmem1[8'h40] = 16'h1234;
    mem_wait = 4;
    do_reset();
    step(4);
    check("lwd_read", {31'b0, r0}, 32'd1);
    check("lwd_addr", {24'b0, a0}, 32'h40);
    step(1);
    rst = 1'b1;
    step(1);
    check("rst_mid_strobes", {28'b0, r0, w0, r1, w1}, 32'd0);
    check("rst_mid_addr", {16'b0, a0, a1}, 32'd0);
    check_pc("rst_mid", 32'd0);
    clear_prog();
    imem[0] = ins(OP_SWI, 8'd0, 8'd6, 8'h41);
    imem[1] = ins(OP_SWI, 8'd0, 8'd2, 8'h42);
    expect_store(8'h41, 8'h00, 16'h0000);
    expect_store(8'h42, 8'h00, 16'h0000);
    mem_wait = 0;
    rst = 1'b0;
    step(6);
    check_pc("rst_mid_after", 32'd8);
    check_drained("rst_mid");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_multicycle.md
Name: cpu_multicycle

Overview:
- Parametrised multi-cycle successor to the team's single-cycle 8-bit CPU core.
- Same 32-bit instruction format and opcode set, extended with shifts and data-memory load/store.
- Adds a FETCH/EXEC/MEM/WB state machine and busywait handshakes to instruction and data memory, so slow or cached memories stall the core instead of breaking it.
- Sits between instruction memory, data memory/cache and the testbench.

Parameters:
- DATA_W, 8, register/ALU data width (>=8).
- NREGS, 8, number of general registers (power of 2, 2..256). IDX_W = clog2(NREGS).
- ADDR_W, 8, data-memory address width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- PC  out  32  instruction address.
- INSTRUCTION  in  32  instruction word from instruction memory.
- INSTR_BUSYWAIT  in  1  high = INSTRUCTION not yet valid.
- MEM_READ  out  1  data read strobe.
- MEM_WRITE  out  1  data write strobe.
- MEM_ADDR  out  ADDR_W  data address.
- MEM_WRITEDATA  out  DATA_W  store data.
- MEM_READDATA  in  DATA_W  load data.
- MEM_BUSYWAIT  in  1  high = data access not complete.

Behaviour:
- Reset: one clock and one synchronous, active-high reset. At a rising CLK edge with RESET=1: PC=0, state=FETCH, all registers=0, IR=0. MEM_READ, MEM_WRITE, MEM_ADDR and MEM_WRITEDATA are all 0 while in FETCH, so they are 0 after reset. Reset overrides everything, including mid-MEM: strobes drop the cycle after the reset edge, and no register write or PC update occurs.
- Instruction fields: opcode=[31:24], dest/offset=[23:16], src1=[15:8], src2/imm=[7:0]. Register index = field[IDX_W-1:0]; upper bits are ignored. No hardwired-zero register.
- FETCH: hold PC. On an edge with INSTR_BUSYWAIT=0, latch INSTRUCTION into IR and go to EXEC. Otherwise stay in FETCH.
- EXEC (1 cycle): decode IR and compute the ALU result.
  - loadi(0), mov(1), add(2), sub(3), and(4), or(5), sll(13), srl(14): write dest, PC<=PC+4, go to FETCH.
  - j(6), beq(7), bne(8): no write. PC<=target if taken, else PC+4. Go to FETCH.
  - lwd(9), lwi(10), swd(11), swi(12): latch address and store data, go to MEM.
  - Undefined opcode: NOP (PC+4, no write).
- Arithmetic: results wrap modulo 2^DATA_W. sub = a + ~b + 1. The immediate is sign-extended from 8 bits to DATA_W. Shift amount = imm; if the amount >= DATA_W the result is 0. srl is logical.
- Branch target = PC + 4 + (sext(offset) << 2), computed in 32 bits with wrap.
  - beq taken when reg[src1] - reg[src2] == 0.
  - bne taken when the difference != 0.
  - j is always taken.
- Addresses: lwd/swd use reg[src2]; lwi/swi use imm. Store data = reg[src1]. Values are truncated or zero-extended to ADDR_W.
- MEM:
  - Assert MEM_READ for loads or MEM_WRITE for stores. MEM_ADDR and MEM_WRITEDATA stay stable while the strobe is high.
  - Completion is the first edge in MEM with MEM_BUSYWAIT=0. Loads capture MEM_READDATA at that edge and go to WB. Stores set PC<=PC+4 and go to FETCH.
  - While BUSYWAIT=1, stay in MEM with all outputs held.
  - MEM_READ and MEM_WRITE are never high together.
- WB (1 cycle): write the load data to dest, PC<=PC+4, go to FETCH.
- Minimum latency with zero-wait memories: ALU/branch 2 cycles, store 3, load 4. Each busywait cycle adds exactly one cycle.
- Register write occurs only in EXEC (ALU ops) or WB (loads).
- Reads in EXEC see all prior writes: there is no overlap, so no forwarding is needed.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams (OP_LOADI..OP_SRL);
  - the state enum (S_FETCH, S_EXEC, S_MEM, S_WB);
  - ALU select codes;
  - instruction field bit positions.
- One sub-module, alu_param (parameter DATA_W):
  - inputs: operand A, operand B, ALU select, shift amount;
  - outputs: result and ZERO.
- The register array, FSM and PC logic stay in cpu_multicycle.

Test Plan:
- Reset then loadi r1,5; loadi r2,3; sub r3,r1,r2 with zero-wait memories -> r3=2, PC=12 after 6 cycles, MEM strobes never high.
- DATA_W=8: loadi r1,0x7F; loadi r2,1; add r3,r1,r2 -> r3=0x80 (wrap). sll r4,r2 by 9 -> r4=0.
- beq offset=-2 with equal operands at PC=8 -> PC=4. bne with the same operands -> PC=12. j offset=+3 at PC=0 -> PC=16.
- swi r1(=0x2A) to 0x10 with 3 busywait cycles -> MEM_WRITE high for 4 cycles, addr 0x10, data 0x2A stable; then lwi r5,0x10 -> r5=0x2A, WB one cycle after busywait falls.
- INSTR_BUSYWAIT high 5 cycles in FETCH -> PC held, no register change, EXEC follows the release edge.
- RESET asserted during the 2nd busywait cycle of lwd -> next cycle strobes=0, PC=0, state FETCH, dest register unchanged (0). Repeat the register tests with NREGS=16, DATA_W=16.
